// File: rtl/uart_tx_sched.sv
// Round-robin UART transmit scheduler: N_REQ byte producers share one TXD line.
// The baud timer restarts at every grant, so each frame is exactly 10*DIV cycles
// of 8N1 framing: start bit, 8 data bits LSB first, stop bit.
module uart_tx_sched #(
  parameter int N_REQ = 4,
  parameter int DIV   = 10416
) (
  input  logic                 CLK100MHZ,
  input  logic                 RST,
  input  logic [N_REQ-1:0]     req,
  input  logic [8*N_REQ-1:0]   data,
  output logic [N_REQ-1:0]     gnt,
  output logic                 busy,
  output logic                 done,
  output logic                 TXD
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t            state, state_nxt;
  logic [PW-1:0]     ptr, ptr_nxt;
  logic [2:0]        bitcnt, bitcnt_nxt;
  logic [CW-1:0]     baud, baud_nxt;
  logic [7:0]        shift, shift_nxt;
  logic [N_REQ-1:0]  gnt_nxt;
  logic              busy_nxt, done_nxt, txd_nxt;
  logic              baud_tc;
  logic              sel_vld;
  logic [PW-1:0]     sel_idx;
  logic [7:0]        sel_byte;

  assign baud_tc  = (baud == CW'(DIV - 1));
  assign sel_byte = data[8*int'(sel_idx) +: 8];

  // Round-robin pick: first requester at or above the pointer, wrapping.
  // Scanning from the far end down lets the nearest candidate win last.
  always_comb begin
    int idx;
    idx     = 0;
    sel_vld = 1'b0;
    sel_idx = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % N_REQ;
      if (req[idx]) begin
        sel_vld = 1'b1;
        sel_idx = PW'(idx);
      end
    end
  end

  // Next-state and next-output logic; every output is taken from a register.
  always_comb begin
    state_nxt  = state;
    ptr_nxt    = ptr;
    bitcnt_nxt = bitcnt;
    baud_nxt   = baud_tc ? '0 : baud + CW'(1);
    shift_nxt  = shift;
    gnt_nxt    = '0;
    busy_nxt   = busy;
    done_nxt   = 1'b0;
    txd_nxt    = TXD;
    case (state)
      IDLE: begin
        baud_nxt = baud;
        txd_nxt  = 1'b1;
        if (sel_vld) begin
          shift_nxt = sel_byte;
          gnt_nxt   = N_REQ'(1) << sel_idx;
          busy_nxt  = 1'b1;
          txd_nxt   = 1'b0;
          baud_nxt  = '0;
          ptr_nxt   = PW'((int'(sel_idx) + 1) % N_REQ);
          state_nxt = START;
        end
      end
      START: begin
        if (baud_tc) begin
          state_nxt  = DATA;
          bitcnt_nxt = 3'd0;
          txd_nxt    = shift[0];
        end
      end
      DATA: begin
        if (baud_tc) begin
          shift_nxt  = shift >> 1;
          bitcnt_nxt = bitcnt + 3'd1;
          if (bitcnt == 3'd7) begin
            state_nxt = STOP;
            txd_nxt   = 1'b1;
          end else begin
            txd_nxt = shift[1];
          end
        end
      end
      STOP: begin
        if (baud_tc) begin
          state_nxt = IDLE;
          busy_nxt  = 1'b0;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and output registers; reset aborts any frame in flight.
  always_ff @(posedge CLK100MHZ) begin
    if (RST) begin
      state  <= IDLE;
      ptr    <= '0;
      bitcnt <= 3'd0;
      baud   <= '0;
      shift  <= 8'd0;
      gnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      TXD    <= 1'b1;
    end else begin
      state  <= state_nxt;
      ptr    <= ptr_nxt;
      bitcnt <= bitcnt_nxt;
      baud   <= baud_nxt;
      shift  <= shift_nxt;
      gnt    <= gnt_nxt;
      busy   <= busy_nxt;
      done   <= done_nxt;
      TXD    <= txd_nxt;
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Scoreboard bench for uart_tx_sched at DIV=4, N_REQ=4. Stimulus pushes the
// expected grant (index, byte, spacing) into a queue; a monitor pops on every
// grant and then follows the frame cycle by cycle.
module tb_uart_tx_sched;
  localparam int N = 4;
  localparam int D = 4;

  logic           clk;
  logic           rst;
  logic [N-1:0]   req;
  logic [8*N-1:0] data;
  logic [N-1:0]   gnt;
  logic           busy, done, txd;

  uart_tx_sched #(.N_REQ(N), .DIV(D)) dut (
    .CLK100MHZ(clk), .RST(rst), .req(req), .data(data),
    .gnt(gnt), .busy(busy), .done(done), .TXD(txd)
  );

  typedef struct {
    int         idx;
    logic [7:0] byt;
    int         gap;   // cycles since previous grant, -1 = don't care
  } exp_t;

  exp_t q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  logic rst_q = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= rst;
  end

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    vectors++;
    if (a !== e) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, a, e, cyc);
    end
  endtask

  task automatic monitor();
    bit         act = 0;
    int         gcyc = 0;
    int         lastg = 0;
    int         t, b;
    logic [7:0] byt = 8'h00;
    logic       ebit;
    exp_t       e;
    forever begin
      @(negedge clk);
      if (rst_q) begin
        chk("reset_state", {gnt, busy, done, txd}, {{N{1'b0}}, 3'b001});
        act = 0;
      end else begin
        if (gnt != '0) begin
          if (act) chk("gnt_in_frame", 32'(gnt), 32'd0);
          if (q.size() == 0) begin
            chk("unexpected_gnt", 32'(gnt), 32'd0);
          end else begin
            e = q.pop_front();
            chk("gnt_onehot", 32'(gnt), 32'(1) << e.idx);
            if (e.gap >= 0) chk("gnt_spacing", 32'(cyc - lastg), 32'(e.gap));
            act   = 1;
            gcyc  = cyc;
            lastg = cyc;
            byt   = e.byt;
          end
        end
        if (act) begin
          t = cyc - gcyc;
          if (t < 10*D) begin
            b = t / D;
            if (b == 0)      ebit = 1'b0;
            else if (b <= 8) ebit = byt[b-1];
            else             ebit = 1'b1;
            chk($sformatf("frame_t%0d", t), {busy, done, txd}, {2'b10, ebit});
          end else begin
            chk("frame_done", {gnt, busy, done, txd}, {{N{1'b0}}, 3'b011});
            act = 0;
          end
        end else if (gnt == '0) begin
          chk("idle_line", {busy, done, txd}, 3'b001);
        end
      end
    end
  endtask

  // Wait (bounded) for the next negedge showing a grant.
  task automatic wait_gnt(input string nm);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (gnt == '0 && n < 300);
    if (gnt == '0) chk({nm, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic pulse_rst();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst  = 1'b1;
    req  = '0;
    data = 32'h44332211;
    fork monitor(); join_none
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Single frame from requester 2, alternating pattern 0x55.
    data[23:16] = 8'h55;
    q.push_back('{2, 8'h55, -1});
    req = 4'b0100;
    wait_gnt("t1");
    req = '0;
    repeat (45) @(negedge clk);

    // Continuous load on all four: 0,1,2,3,0 spaced 10*D+1 apart.
    pulse_rst();
    data = 32'h44332211;
    q.push_back('{0, 8'h11, -1});
    q.push_back('{1, 8'h22, 10*D+1});
    q.push_back('{2, 8'h33, 10*D+1});
    q.push_back('{3, 8'h44, 10*D+1});
    q.push_back('{0, 8'h11, 10*D+1});
    req = 4'b1111;
    for (int i = 0; i < 5; i++) wait_gnt("t2");
    req = '0;
    repeat (45) @(negedge clk);

    // Grant to 2, then 1010 held: 3 next, then 1.
    pulse_rst();
    q.push_back('{2, 8'h33, -1});
    req = 4'b0100;
    wait_gnt("t3a");
    req = 4'b1010;
    q.push_back('{3, 8'h44, 10*D+1});
    q.push_back('{1, 8'h22, 10*D+1});
    wait_gnt("t3b");
    wait_gnt("t3c");
    req = '0;
    repeat (45) @(negedge clk);

    // req[1] pulsed for one cycle mid-frame must never be served.
    q.push_back('{0, 8'h11, -1});
    req = 4'b0001;
    wait_gnt("t4");
    req = '0;
    repeat (5) @(negedge clk);
    req = 4'b0010;
    @(negedge clk);
    req = '0;
    repeat (60) @(negedge clk);

    // Reset during data bit 3 of 0xA5; new frame starts right after.
    data[7:0] = 8'hA5;
    q.push_back('{0, 8'hA5, -1});
    req = 4'b0001;
    wait_gnt("t5a");
    repeat (17) @(negedge clk);
    rst = 1'b1;
    q.push_back('{0, 8'hA5, 19});
    @(negedge clk);
    rst = 1'b0;
    wait_gnt("t5b");
    req = '0;
    repeat (45) @(negedge clk);

    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
